// File: rtl/ipsec_mem_stream_reader.sv
// ipsec_mem_stream_reader
// Reads a contiguous block of 32-bit words from the packet RAM (Avalon-MM
// master on the RAM's s1 port) and streams it out as one Avalon-ST packet.
// A small first-word-fall-through FIFO absorbs the RAM's one-cycle read
// latency. Reads are credit-gated, so backpressure never loses a word.
//
// Ports
//   clk, reset         : single clock, synchronous active-high reset
//   start              : one-cycle request, honoured only while idle
//   start_addr         : first word address
//   length_words       : word count, 1..2^ADDR_W (0 is ignored)
//   busy / done        : transfer in progress / one-cycle completion pulse
//   mem_*              : Avalon-MM read master toward the RAM
//   out_*              : Avalon-ST source with SOP/EOP framing
module ipsec_mem_stream_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_startofpacket,
    output logic              out_endofpacket
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   cur_addr_reg;
    logic [ADDR_W:0]     remaining_reg;
    logic [ADDR_W:0]     word_idx_reg;
    logic [ADDR_W:0]     length_reg;
    logic                pending_reg;
    logic                done_reg;
    logic [CNT_W-1:0]    count_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;

    // Each entry holds {eop, sop, data}.
    logic [33:0]         fifo_mem [FIFO_DEPTH];

    logic [CNT_W:0]      credit_used;
    logic                issue;
    logic                push;
    logic                pop;
    logic                empty;
    logic [33:0]         head;
    logic                cap_sop;
    logic                cap_eop;

    // Credits use the registered count only; a pop in this cycle does not
    // free a slot until the next cycle, which keeps the FIFO from overflowing
    // when the read issued now lands one cycle later.
    assign credit_used = (CNT_W+1)'(count_reg) + (CNT_W+1)'(pending_reg);
    assign issue       = (state_reg == ISSUE) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign push        = pending_reg;
    assign empty       = (count_reg == '0);
    assign head        = fifo_mem[rd_ptr_reg];
    assign pop         = out_valid && out_ready;

    assign cap_sop = (word_idx_reg == '0);
    assign cap_eop = (word_idx_reg == length_reg - (ADDR_W+1)'(1));

    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign mem_address    = cur_addr_reg;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;

    // Gate the head with empty so the stream outputs read as zero when idle
    // (and after reset) regardless of stale FIFO contents.
    assign out_valid         = !empty;
    assign out_data          = empty ? 32'd0 : head[31:0];
    assign out_startofpacket = !empty && head[32];
    assign out_endofpacket   = !empty && head[33];

    // Storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cap_eop, cap_sop, mem_readdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            remaining_reg <= '0;
            word_idx_reg  <= '0;
            length_reg    <= '0;
            pending_reg   <= 1'b0;
            done_reg      <= 1'b0;
            count_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            done_reg    <= 1'b0;
            pending_reg <= issue;

            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                word_idx_reg <= word_idx_reg + (ADDR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);

            case (state_reg)
                IDLE: begin
                    if (start && (length_words != '0)) begin
                        cur_addr_reg  <= start_addr;
                        remaining_reg <= length_words;
                        length_reg    <= length_words;
                        word_idx_reg  <= '0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        cur_addr_reg  <= cur_addr_reg + ADDR_W'(1);
                        remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
                        if (remaining_reg == (ADDR_W+1)'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Only the final word carries EOP, so accepting it means
                    // the FIFO is emptying and nothing is left in flight.
                    if (pop && head[33]) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipsec_mem_stream_reader.sv
// Self-checking bench for ipsec_mem_stream_reader with a behavioural 2048x32
// RAM (one-cycle registered read) and a scoreboard of expected beats.
module tb_ipsec_mem_stream_reader;

    localparam int DEPTH = 4;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length_words;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect;
    logic          mem_write;
    logic [3:0]    mem_byteenable;
    logic          mem_clken;
    logic [31:0]   mem_readdata;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_startofpacket;
    logic          out_endofpacket;

    ipsec_mem_stream_reader #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_addr        (start_addr),
        .length_words      (length_words),
        .busy              (busy),
        .done              (done),
        .mem_address       (mem_address),
        .mem_chipselect    (mem_chipselect),
        .mem_write         (mem_write),
        .mem_byteenable    (mem_byteenable),
        .mem_clken         (mem_clken),
        .mem_readdata      (mem_readdata),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [2048];
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       sb[$];
    int          addr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;
    int          outstanding = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_beat = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops, stall stability and read-credit bound.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_chipselect) begin
                addr_q.push_back(int'(mem_address));
                outstanding++;
            end
            if (prev_stall) begin
                check("stall_stable",
                      {30'd0, out_valid, out_endofpacket, out_startofpacket, out_data},
                      {30'd0, 1'b1, prev_beat});
            end
            if (out_valid && out_ready) begin
                beat_t e;
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat", {30'd0, out_endofpacket, out_startofpacket, out_data},
                          {30'd0, e.eop, e.sop, e.d});
                end
                if (out_startofpacket) sop_cyc = cyc;
                if (out_endofpacket)   eop_cyc = cyc;
                outstanding--;
            end
            check("outstanding_le_depth", 64'(outstanding <= DEPTH), 64'd1);
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_endofpacket, out_startofpacket, out_data};
        end else begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end
    end

    // mode 0: ready high; 1: random 50%; 2: ready low for cycles 8..27.
    task automatic run_packet(input int addr, input int len, input int mode,
                              output int c0, output int dcyc);
        bit got;
        addr_q.delete();
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b.d   = ram[(addr + k) % 2048];
            b.sop = (k == 0);
            b.eop = (k == len - 1);
            sb.push_back(b);
        end
        start_addr   = AW'(addr);
        length_words = (AW+1)'(len);
        start        = 1'b1;
        out_ready    = 1'b1;
        c0           = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_cycle1", 64'(busy), 64'd1);
        check("cs_cycle1", 64'(mem_chipselect), 64'd1);
        check("addr_cycle1", 64'(mem_address), 64'(addr));
        got  = 1'b0;
        dcyc = -1;
        for (int i = 1; i < 3000 && !got; i++) begin
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(i >= 8 && i < 28);
                default: out_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        check("busy_low_at_done", 64'(busy), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("packet addr=%0d len=%0d mode=%0d start_cyc=%0d done_cyc=%0d", addr, len, mode, c0, dcyc);
    endtask

    initial begin
        int c0, dc;
        logic seen;

        for (int i = 0; i < 2048; i++) ram[i] = (32'(i) * 32'h9E3779B1) ^ 32'hC0FFEE00;
        ram[0] = 32'h11111111;
        ram[1] = 32'h22222222;
        ram[2] = 32'h33333333;
        ram[3] = 32'h44444444;

        reset = 1'b1; start = 1'b0; start_addr = '0; length_words = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cs", 64'(mem_chipselect), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sop", 64'(out_startofpacket), 64'd0);
        check("rst_eop", 64'(out_endofpacket), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("const_write", 64'(mem_write), 64'd0);
        check("const_be", 64'(mem_byteenable), 64'hF);
        check("const_clken", 64'(mem_clken), 64'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Four-word packet with exact cycle timing.
        run_packet(0, 4, 0, c0, dc);
        check("first_word_cycle", 64'(sop_cyc - c0), 64'd3);
        check("last_word_cycle", 64'(eop_cyc - c0), 64'd6);
        check("done_cycle", 64'(dc - c0), 64'd7);

        // Back-to-back start in the done cycle, across the address wrap.
        run_packet(2046, 4, 0, c0, dc);
        check("wrap_addr_count", 64'(addr_q.size()), 64'd4);
        for (int k = 0; k < addr_q.size(); k++) check("wrap_addr", 64'(addr_q[k]), 64'((2046 + k) % 2048));

        // Single-word packet: SOP and EOP on the same beat.
        run_packet(500, 1, 0, c0, dc);
        check("single_done_cycle", 64'(dc - c0), 64'd4);
        check("single_sop_eop_cycle", 64'(eop_cyc - sop_cyc), 64'd0);

        // Zero-length start is ignored.
        @(posedge clk); #1;
        start_addr = 11'd7; length_words = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | busy | done | mem_chipselect | out_valid;
            @(posedge clk); #1;
        end
        check("zero_len_ignored", 64'(seen), 64'd0);
        $display("zero-length start: activity=%0b", seen);

        // Random backpressure and a long stall mid-packet.
        run_packet(1000, 64, 1, c0, dc);
        run_packet(1500, 40, 2, c0, dc);

        // Reset in cycle 5 of a 16-word read.
        for (int k = 0; k < 16; k++) begin
            beat_t b;
            b.d = ram[100 + k]; b.sop = (k == 0); b.eop = (k == 15);
            sb.push_back(b);
        end
        start_addr = 11'd100; length_words = 12'd16; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_cs", 64'(mem_chipselect), 64'd0);
        check("mid_rst_addr", 64'(mem_address), 64'd0);
        check("mid_rst_out", {29'd0, out_valid, out_startofpacket, out_endofpacket, out_data}, 64'd0);
        $display("reset mid-packet: %0d expected beats discarded", sb.size());
        sb.delete();
        @(posedge clk); #1;
        run_packet(100, 16, 0, c0, dc);

        @(posedge clk); #1;
        check("final_outstanding", 64'(outstanding), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
